// File: rtl/int_div_base.sv
// int_div_base: unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, reset (async active-low); istream val/rdy/msg {dividend,divisor};
//        ostream val/rdy/msg {remainder,quotient}.
module int_div_base #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits-1:0]   istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [2*p_nbits-1:0]   ostream_msg
);

  localparam int CW = $clog2(p_nbits);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [p_nbits:0]   rem;
  logic [p_nbits-1:0] quo;
  logic [p_nbits-1:0] dvs;

  logic [p_nbits:0]   rem_sh;
  logic [p_nbits:0]   diff;
  logic               last;
  logic               load;
  logic               step;

  // Shift {rem,quo} left by one; the extra rem bit keeps the borrow.
  assign rem_sh = {rem[p_nbits-1:0], quo[p_nbits-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign last   = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = IDLE;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          load     = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        step     = 1'b1;
        state_nx = last ? DONE : CALC;
      end
      DONE: begin
        ostream_val = 1'b1;
        state_nx    = ostream_rdy ? IDLE : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      cnt <= '0;
      rem <= '0;
      quo <= istream_msg[2*p_nbits-1:p_nbits];
      dvs <= istream_msg[p_nbits-1:0];
    end else if (step) begin
      cnt <= cnt + CW'(1);
      // Negative trial result: restore (keep shifted value), bit is 0.
      rem <= diff[p_nbits] ? rem_sh : diff;
      quo <= {quo[p_nbits-2:0], ~diff[p_nbits]};
    end
  end

  assign ostream_msg = {rem[p_nbits-1:0], quo};

endmodule
